// File: rtl/nibble_serial_add_ctrl.sv
// Multi-precision add/subtract using one 4-bit lookahead slice,
// one nibble per clock, LSB nibble first, carry held between cycles.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [3:0] a_n;
  logic [3:0] b_n;
  logic [3:0] g;
  logic [3:0] p;
  logic       c0, c1, c2, c3;
  logic [3:0] s_n;
  logic       last;

  // Lookahead slice on the nibble selected by the counter
  always_comb begin
    a_n = 4'(a_q >> {cnt, 2'b00});
    b_n = 4'(b_q >> {cnt, 2'b00});
    g   = a_n & b_n;
    p   = a_n ^ b_n;
    c0  = g[0] | (p[0] & carry);
    c1  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c2  = g[2] | (p[2] & c1);
    c3  = g[3] | (p[3] & c2);
    s_n = p ^ {c2, c1, c0, carry};
    last = (cnt == CW'(NIBBLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b ^ {W{sub}};
            carry <= c_in ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) sum[4*i +: 4] <= s_n;
          end
          carry <= c3;
          cnt   <= cnt + CW'(1);
          if (last) begin
            c_out <= c3;
            ovf   <= c3 ^ c2;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl (NIBBLES=4 main DUT,
// plus a NIBBLES=1 instance for the single-nibble case).
module tb_nibble_serial_add_ctrl;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;

  logic       start1;
  logic       sub1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       c_in1;
  logic       busy1;
  logic       done1;
  logic [3:0] sum1;
  logic       c_out1;
  logic       ovf1;

  int checks;
  int errors;
  int done_cnt;
  exp_t sb[$];

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .c_in(c_in), .busy(busy), .done(done),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1),
    .a(a1), .b(b1), .c_in(c_in1), .busy(busy1), .done(done1),
    .sum(sum1), .c_out(c_out1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_,
                                 input logic ts, input logic tc);
    exp_t e;
    logic [15:0] y;
    logic [16:0] r;
    y = tb_ ^ {16{ts}};
    r = {1'b0, ta} + {1'b0, y} + 17'(tc ^ ts);
    e.s  = r[15:0];
    e.co = r[16];
    e.ov = (ta[15] == y[15]) && (r[15] != ta[15]);
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("c_out", 32'(c_out), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ts, input logic tc, input exp_t e);
    int k;
    wait_idle();
    a = ta;
    b = tb_;
    sub = ts;
    c_in = tc;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_run", 32'(busy), 32'd1);
    wait_done(k);
    chk("latency", 32'(k), 32'd5);
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic co,
                              input logic ov);
    exp_t e;
    e.s = s;
    e.co = co;
    e.ov = ov;
    return e;
  endfunction

  initial begin
    int k;
    int d;
    int n;
    int last;
    int dc0;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rs;
    logic rc;
    checks = 0;
    errors = 0;
    done_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    start1 = 1'b0;
    sub1 = 1'b0;
    a1 = '0;
    b1 = '0;
    c_in1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    run_op(16'h00FF, 16'h0000, 1'b0, 1'b1, mk(16'h0100, 1'b0, 1'b0));
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, mk(16'hFFFE, 1'b0, 1'b0));
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, mk(16'h7FFF, 1'b1, 1'b1));
    run_op(16'h0010, 16'h0000, 1'b1, 1'b1, mk(16'h000F, 1'b1, 1'b0));
    chk("held_sum", 32'(sum), 32'h000F);

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rs, rc, model(ra, rb, rs, rc));
    end

    // start re-pulsed and a changed while the op is in flight
    wait_idle();
    dc0 = done_cnt;
    a = 16'h1111;
    b = 16'h2222;
    sub = 1'b0;
    c_in = 1'b0;
    start = 1'b1;
    sb.push_back(mk(16'h3333, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a = 16'hFFFF;
    sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    repeat (10) @(negedge clk);
    chk("one_done", 32'(done_cnt - dc0), 32'd1);

    // continuous start
    wait_idle();
    a = 16'h0F0F;
    b = 16'h0101;
    sub = 1'b0;
    c_in = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(mk(16'h1011, 1'b0, 1'b0));
    start = 1'b1;
    d = 0;
    n = 0;
    last = 0;
    while (d < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (d > 0) chk("period", 32'(n - last), 32'd6);
        last = n;
        d++;
      end
    end
    start = 1'b0;
    chk("cont_count", 32'(d), 32'd3);
    @(negedge clk);

    // reset during RUN
    wait_idle();
    dc0 = done_cnt;
    a = 16'h1234;
    b = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_sum", 32'(sum), 32'd0);
    chk("mid_cout", 32'(c_out), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_done", 32'(done_cnt - dc0), 32'd0);

    // single-nibble instance
    a1 = 4'hF;
    b1 = 4'h1;
    sub1 = 1'b0;
    c_in1 = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_sum", 32'(sum1), 32'd0);
    chk("n1_cout", 32'(c_out1), 32'd1);
    chk("n1_ovf", 32'(ovf1), 32'd0);
    @(negedge clk);
    chk("n1_pulse", 32'(done1), 32'd0);

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
